// File: rtl/wb_stage.sv
// Writeback stage: accepts ALU results and loads, extracts load data from the
// aligned memory word, and drives the register-file write port.
// Optional operand bypass outputs are built when WB_FWD_EN is defined.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [4:0]  o_write_addr,
  output logic [31:0] o_write_data,
  output logic        o_write_en,
  output logic        o_misaligned,
  output logic [31:0] o_retire_count
`ifdef WB_FWD_EN
  ,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_addr,
  output logic [31:0] o_fwd_data
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        mis_q, mis_d;
  logic [31:0] retire_q, retire_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic        accept;
  logic        load_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign o_ready = (state_q != WAIT_MEM);
  assign accept  = i_valid & o_ready & clk_en;

  // Legality of an incoming load: width/alignment and defined funct3 codes
  always_comb begin
    load_ok = 1'b0;
    case (i_funct3)
      3'd0, 3'd4: load_ok = 1'b1;
      3'd1, 3'd5: load_ok = ~i_addr_lo[0];
      3'd2:       load_ok = (i_addr_lo == 2'd0);
      default:    load_ok = 1'b0;
    endcase
  end

  // Load data extraction from the returned word using the latched width/offset
  always_comb begin
    ld_byte = i_mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = ld_off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (ld_f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    mis_d     = 1'b0;
    retire_d  = retire_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    if (accept) begin
      if (!i_is_load) begin
        state_d   = WRITE;
        wr_addr_d = i_rd;
        wr_data_d = i_result;
        wr_en_d   = (i_rd != 5'd0);
        retire_d  = retire_q + 32'd1;
      end else if (load_ok) begin
        state_d  = WAIT_MEM;
        ld_rd_d  = i_rd;
        ld_f3_d  = i_funct3;
        ld_off_d = i_addr_lo;
      end else begin
        state_d = IDLE;
        mis_d   = 1'b1;
      end
    end else begin
      case (state_q)
        WAIT_MEM: begin
          if (i_mem_rvalid) begin
            state_d   = WRITE;
            wr_addr_d = ld_rd_q;
            wr_data_d = ld_data;
            wr_en_d   = (ld_rd_q != 5'd0);
            retire_d  = retire_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers: reset wins over the stall, stall freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      mis_q     <= 1'b0;
      retire_q  <= '0;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      mis_q     <= mis_d;
      retire_q  <= retire_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
    end
  end

  assign o_write_addr   = wr_addr_q;
  assign o_write_data   = wr_data_q;
  assign o_write_en     = wr_en_q;
  assign o_misaligned   = mis_q;
  assign o_retire_count = retire_q;

`ifdef WB_FWD_EN
  assign o_fwd_valid = wr_en_q & (wr_addr_q != 5'd0);
  assign o_fwd_addr  = wr_addr_q;
  assign o_fwd_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, clk_en, i_valid, o_ready;
  logic [4:0]  i_rd;
  logic [31:0] i_result;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lo;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [4:0]  o_write_addr;
  logic [31:0] o_write_data;
  logic        o_write_en, o_misaligned;
  logic [31:0] o_retire_count;
`ifdef WB_FWD_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_addr;
  logic [31:0] o_fwd_data;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_valid(i_valid), .o_ready(o_ready), .i_rd(i_rd), .i_result(i_result),
    .i_is_load(i_is_load), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_write_addr(o_write_addr), .o_write_data(o_write_data),
    .o_write_en(o_write_en), .o_misaligned(o_misaligned),
    .o_retire_count(o_retire_count)
`ifdef WB_FWD_EN
    , .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_data(o_fwd_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: a pending-load flag plus the last presented write result
  bit          m_pend;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  bit          m_wen, m_mis;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_cnt;

  function automatic bit ld_legal(input int unsigned f3, input int unsigned off);
    case (f3)
      0, 4:    return 1'b1;
      1, 5:    return (off % 2) == 0;
      2:       return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_value(input int unsigned f3, input int unsigned off,
                                           input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * off)) % 256;
    h = (word >> (16 * (off / 2))) % 65536;
    case (f3)
      0:       return (b >= 128) ? (32'hFFFF_FF00 | b) : b;
      4:       return b;
      1:       return (h >= 32768) ? (32'hFFFF_0000 | h) : h;
      5:       return h;
      default: return word;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] rd, input logic [31:0] d);
    m_addr = rd;
    m_data = d;
    m_wen  = (rd != 0);
    m_cnt  = m_cnt + 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pend = 0; m_wen = 0; m_mis = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else if (clk_en) begin
      m_wen = 0;
      m_mis = 0;
      if (i_valid && !m_pend) begin
        if (!i_is_load) m_write(i_rd, i_result);
        else if (ld_legal(i_funct3, i_addr_lo)) begin
          m_pend = 1; m_rd = i_rd; m_f3 = i_funct3; m_off = i_addr_lo;
        end else m_mis = 1;
      end else if (m_pend && i_mem_rvalid) begin
        m_pend = 0;
        m_write(m_rd, ld_value(m_f3, m_off, i_mem_rdata));
      end
    end
  endtask

  task automatic check_outs();
    chk("ready", o_ready, !m_pend);
    chk("wen", o_write_en, m_wen);
    chk("waddr", o_write_addr, m_addr);
    chk("wdata", o_write_data, m_data);
    chk("misaligned", o_misaligned, m_mis);
    chk("retire", o_retire_count, m_cnt);
`ifdef WB_FWD_EN
    chk("fwd_valid", o_fwd_valid, m_wen && (m_addr != 0));
    chk("fwd_addr", o_fwd_addr, m_addr);
    chk("fwd_data", o_fwd_data, m_data);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic drive(input bit v, input bit ld, input logic [4:0] rd, input logic [31:0] res,
                       input logic [2:0] f3, input logic [1:0] off);
    i_valid = v; i_is_load = ld; i_rd = rd; i_result = res; i_funct3 = f3; i_addr_lo = off;
  endtask

  logic [31:0] cnt0;

  initial begin
    rst = 1; clk_en = 1; i_mem_rvalid = 0; i_mem_rdata = '0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tick();
    tick();
    chk("reset_retire", o_retire_count, 32'd0);
    rst = 0;
    tick();
    chk("ready_after_reset", o_ready, 1'b1);

    // ALU result written with one-cycle latency
    drive(1, 0, 5'd5, 32'h1234_5678, 0, 0);
    tick();
    chk("alu_wen", o_write_en, 1'b1);
    chk("alu_addr", o_write_addr, 32'd5);
    chk("alu_data", o_write_data, 32'h1234_5678);
    chk("alu_retire", o_retire_count, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // LB then LBU at offset 3 with three wait cycles
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 5'd7, 32'hDEAD_BEEF, (k == 0) ? 3'd0 : 3'd4, 2'd3);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      for (int w = 0; w < 3; w++) begin
        tick();
        chk("load_wait_ready", o_ready, 1'b0);
      end
      i_mem_rvalid = 1; i_mem_rdata = 32'h80FF_FFFF;
      tick();
      i_mem_rvalid = 0;
      chk("load_wen", o_write_en, 1'b1);
      chk("load_data", o_write_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
    end

    // Misaligned LW
    cnt0 = o_retire_count;
    drive(1, 1, 5'd3, 0, 3'd2, 2'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mis_pulse", o_misaligned, 1'b1);
    chk("mis_wen", o_write_en, 1'b0);
    chk("mis_retire", o_retire_count, cnt0);
    chk("mis_ready", o_ready, 1'b1);
    tick();
    chk("mis_clear", o_misaligned, 1'b0);

    // Back-to-back ALU ops, then a write to x0
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, r[4:0], 32'hA000_0000 + r, 0, 0);
      tick();
      chk("b2b_wen", o_write_en, 1'b1);
      chk("b2b_addr", o_write_addr, r);
    end
    cnt0 = o_retire_count;
    drive(1, 0, 5'd0, 32'h5555_5555, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_wen", o_write_en, 1'b0);
    chk("x0_retire", o_retire_count, cnt0 + 32'd1);
    tick();

    // Reset while waiting for memory discards the load
    drive(1, 1, 5'd9, 0, 3'd2, 2'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    tick();
    i_mem_rvalid = 0;
    chk("rst_wait_wen", o_write_en, 1'b0);
    chk("rst_wait_data", o_write_data, 32'd0);
    chk("rst_wait_ready", o_ready, 1'b1);

    // Stall for two cycles while in WRITE
    drive(1, 0, 5'd9, 32'h0BAD_F00D, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cnt0 = o_retire_count;
    clk_en = 0;
    tick();
    tick();
    chk("stall_wen", o_write_en, 1'b1);
    chk("stall_retire", o_retire_count, cnt0);
    clk_en = 1;
    tick();
    chk("stall_release_wen", o_write_en, 1'b0);
    chk("stall_release_retire", o_retire_count, cnt0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(199) == 0);
      clk_en       = ($urandom_range(9) != 0);
      i_valid      = ($urandom_range(3) != 0);
      i_is_load    = ($urandom_range(2) == 0);
      i_rd         = 5'($urandom_range(31));
      i_result     = $urandom;
      i_funct3     = 3'($urandom_range(7));
      i_addr_lo    = 2'($urandom_range(3));
      i_mem_rvalid = ($urandom_range(2) == 0);
      i_mem_rdata  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
